// File: rtl/intersection_pkg.sv
// intersection_pkg: shared constants and types for the intersection controller and its timing front end
//   Default timing parameters (in clk cycles per tick and in ticks) plus the
//   request-direction encoding seen by the FSM on req_dir.
package intersection_pkg;

    localparam int TICK_DIV_DEFAULT       = 25_000_000;
    localparam int DEBOUNCE_TICKS_DEFAULT = 2;
    localparam int SHORT_TICKS_DEFAULT    = 3;
    localparam int LONG_TICKS_DEFAULT     = 8;

    typedef enum logic {
        DIR_N = 1'b0,
        DIR_S = 1'b1
    } dir_t;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer, tick-based debouncer and rising-edge press pulse
//   clk, reset_n : clock, asynchronous active-low reset
//   raw          : asynchronous switch input
//   tick         : shared prescaler pulse that paces the debounce counter
//   press        : one-cycle pulse in the cycle whose closing edge raises the debounced level
module sensor_debounce
    import intersection_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    input  logic tick,
    output logic press
);

    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DW-1:0] DC_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic [1:0]    sync;
    logic          deb;
    logic [DW-1:0] dc;
    logic          accept;

    // The synced level has disagreed with deb for DEBOUNCE_TICKS tick edges.
    assign accept = tick && (sync[1] != deb) && (dc == DC_LAST);
    assign press  = accept && sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            deb  <= 1'b0;
            dc   <= '0;
        end else begin
            sync <= {sync[0], raw};
            deb  <= accept ? sync[1] : deb;
            dc   <= (sync[1] == deb || accept) ? '0 : tick ? dc + 1'b1 : dc;
        end
    end

endmodule

// File: rtl/intersection_timing.sv
// intersection_timing: tick prescaler, per-phase T/L timers and debounced N/S request latch
//   clk, reset_n     : clock, asynchronous active-low reset
//   SN, SS           : raw north/south sensor switches
//   phase_start      : FSM state-entry pulse; restarts prescaler and phase counter
//   req_clr          : FSM pulse consuming the pending request
//   T, L             : short/long timer expired, held until next phase_start
//   S, req_dir       : request pending and its direction (0 north, 1 south)
//   tick             : prescaler pulse
module intersection_timing
    import intersection_pkg::*;
#(
    parameter int TICK_DIV       = TICK_DIV_DEFAULT,
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
    parameter int SHORT_TICKS    = SHORT_TICKS_DEFAULT,
    parameter int LONG_TICKS     = LONG_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SN,
    input  logic SS,
    input  logic phase_start,
    input  logic req_clr,
    output logic T,
    output logic L,
    output logic S,
    output logic req_dir,
    output logic tick
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(LONG_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_SHORT = CW'(SHORT_TICKS);
    localparam logic [CW-1:0] CNT_LONG  = CW'(LONG_TICKS);

    logic [PW-1:0] pre;
    logic [CW-1:0] cnt;
    logic          req_n;
    logic          req_s;
    logic          press_n;
    logic          press_s;
    dir_t          dir;

    assign tick = (pre == PRE_LAST);

    // Both timers decode straight from the saturating counter register.
    assign T = (cnt >= CNT_SHORT);
    assign L = (cnt >= CNT_LONG);

    assign S       = req_n | req_s;
    assign dir     = (~req_n & req_s) ? DIR_S : DIR_N;
    assign req_dir = dir;

    sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_n (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (SN),
        .tick    (tick),
        .press   (press_n)
    );

    sensor_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb_s (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (SS),
        .tick    (tick),
        .press   (press_s)
    );

    // phase_start realigns the shared prescaler; the debouncers tolerate the
    // resulting stretch of at most one tick period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre   <= '0;
            cnt   <= '0;
            req_n <= 1'b0;
            req_s <= 1'b0;
        end else begin
            pre   <= (phase_start || tick) ? '0 : pre + 1'b1;
            cnt   <= phase_start ? '0 : (tick && cnt != CNT_LONG) ? cnt + 1'b1 : cnt;
            req_n <= press_n | (req_n & ~req_clr);
            req_s <= press_s | (req_s & ~req_clr);
        end
    end

endmodule

// File: tb/tb_intersection_timing.sv
// tb_intersection_timing: directed and randomized checks of intersection_timing against a tick-level model
module tb_intersection_timing;

    localparam int TD = 4;
    localparam int DB = 2;
    localparam int ST = 3;
    localparam int LT = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic SN = 1'b0;
    logic SS = 1'b0;
    logic phase_start = 1'b0;
    logic req_clr = 1'b0;
    logic T, L, S, req_dir, tick;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    intersection_timing #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DB),
        .SHORT_TICKS    (ST),
        .LONG_TICKS     (LT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .SN          (SN),
        .SS          (SS),
        .phase_start (phase_start),
        .req_clr     (req_clr),
        .T           (T),
        .L           (L),
        .S           (S),
        .req_dir     (req_dir),
        .tick        (tick)
    );

    // Reference model: clk cycles since last alignment, ticks elapsed in the
    // phase, and per sensor the number of tick edges spent disagreeing.
    int         m_age;
    int         m_el;
    int         m_mt [2];
    logic [1:0] m_s1, m_s2, m_deb, m_rq;
    logic       m_tick;

    assign m_tick = (m_age % TD) == TD - 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age <= 0;
            m_el  <= 0;
            m_s1  <= '0;
            m_s2  <= '0;
            m_deb <= '0;
            m_rq  <= '0;
            for (int i = 0; i < 2; i++) m_mt[i] <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] == m_deb[i]) m_mt[i] <= 0;
                else if (m_tick) begin
                    if (m_mt[i] + 1 == DB) begin
                        m_deb[i] <= m_s2[i];
                        m_mt[i]  <= 0;
                    end else m_mt[i] <= m_mt[i] + 1;
                end
                m_rq[i] <= (m_tick && m_s2[i] && !m_deb[i] && m_mt[i] + 1 == DB) || (m_rq[i] && !req_clr);
            end
            m_s1  <= {SS, SN};
            m_s2  <= m_s1;
            m_el  <= phase_start ? 0 : m_el + (m_tick ? 1 : 0);
            m_age <= phase_start ? 0 : m_age + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        req_clr = 1'b1;
        cyc();
        req_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({T, L, S, req_dir, tick} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 00000", {T, L, S, req_dir, tick});
        end
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 3)) begin
                failures++;
                $display("FAIL reset_first_tick edge %0d: got %b expected %b", k, tick, k == 3);
            end
        end
    endtask

    task automatic test_timers();
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        for (int n = 0; n <= 60; n++) begin
            checks++;
            if (T !== (n >= ST * TD) || L !== (n >= LT * TD)) begin
                failures++;
                $display("FAIL timers E0+%0d: got T=%b L=%b expected T=%b L=%b", n, T, L, n >= ST * TD, n >= LT * TD);
            end
            cyc();
        end
    endtask

    task automatic test_glitch();
        int n;
        logic seen;
        SN = 1'b1;
        repeat (3) cyc();
        SN = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            cyc();
            seen |= S;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: got S=%b expected 0", seen);
        end
        SN = 1'b1;
        n = 0;
        while (!S && n < 30) begin
            cyc();
            n++;
        end
        checks++;
        if (n < 7 || n > 10 || req_dir !== 1'b0) begin
            failures++;
            $display("FAIL press_latency: got %0d cycles dir=%b expected 7..10 dir=0", n, req_dir);
        end
    endtask

    task automatic test_consume();
        int n;
        logic seen;
        pulse_clr();
        checks++;
        if (S !== 1'b0) begin
            failures++;
            $display("FAIL consume_clear: got S=%b expected 0", S);
        end
        seen = 1'b0;
        repeat (20) begin
            cyc();
            seen |= S;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL held_no_rerequest: got S=%b expected 0", seen);
        end
        SN = 1'b0;
        repeat (15) cyc();
        SN = 1'b1;
        n = 0;
        while (!S && n < 30) begin
            cyc();
            n++;
        end
        checks++;
        if (S !== 1'b1 || req_dir !== 1'b0 || n > 10) begin
            failures++;
            $display("FAIL repress: got S=%b dir=%b after %0d cycles expected S=1 dir=0 within 10", S, req_dir, n);
        end
        SN = 1'b0;
        repeat (15) cyc();
        pulse_clr();
    endtask

    task automatic test_simultaneous();
        int n;
        checks++;
        if (S !== 1'b0) begin
            failures++;
            $display("FAIL simul_idle: got S=%b expected 0", S);
        end
        SS = 1'b1;
        n = 0;
        while (!S && n < 30) begin
            req_clr = 1'b1;
            cyc();
            n++;
        end
        req_clr = 1'b0;
        checks++;
        if (S !== 1'b1 || req_dir !== 1'b1) begin
            failures++;
            $display("FAIL set_beats_clear: got S=%b dir=%b expected S=1 dir=1", S, req_dir);
        end
        SS = 1'b0;
        repeat (15) cyc();
        pulse_clr();
        SN = 1'b1;
        SS = 1'b1;
        n = 0;
        while (!S && n < 30) begin
            cyc();
            n++;
        end
        checks++;
        if (S !== 1'b1 || req_dir !== 1'b0) begin
            failures++;
            $display("FAIL both_pressed: got S=%b dir=%b expected S=1 dir=0", S, req_dir);
        end
        SN = 1'b0;
        SS = 1'b0;
        repeat (15) cyc();
        pulse_clr();
    endtask

    task automatic test_restart();
        int n;
        n = 0;
        while (!tick && n < 8) begin
            cyc();
            n++;
        end
        checks++;
        if (T !== 1'b1 || tick !== 1'b1) begin
            failures++;
            $display("FAIL restart_pre: got T=%b tick=%b expected 1 1", T, tick);
        end
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        checks++;
        if (T !== 1'b0 || L !== 1'b0) begin
            failures++;
            $display("FAIL restart_clear: got T=%b L=%b expected 0 0", T, L);
        end
        n = 0;
        while (!T && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (n != ST * TD) begin
            failures++;
            $display("FAIL restart_rerise: got %0d cycles expected %0d", n, ST * TD);
        end
    endtask

    task automatic test_reset_mid();
        SN = 1'b1;
        phase_start = 1'b1;
        cyc();
        phase_start = 1'b0;
        repeat (14) cyc();
        checks++;
        if (T !== 1'b1 || S !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: got T=%b S=%b expected 1 1", T, S);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({T, L, S, req_dir, tick} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %b expected 00000", {T, L, S, req_dir, tick});
        end
        SN = 1'b0;
        #2 reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 3)) begin
                failures++;
                $display("FAIL reset_mid_tick edge %0d: got %b expected %b", k, tick, k == 3);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] exp_v;
        int ec;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 11) == 0) SN = ~SN;
            if ($urandom_range(0, 11) == 0) SS = ~SS;
            phase_start = ($urandom_range(0, 39) == 0);
            req_clr = ($urandom_range(0, 14) == 0);
            cyc();
            ec = (m_el < LT) ? m_el : LT;
            exp_v = {ec >= ST, ec >= LT, |m_rq, ~m_rq[0] & m_rq[1], m_tick};
            checks++;
            if ({T, L, S, req_dir, tick} !== exp_v) begin
                failures++;
                $display("FAIL random cycle %0d: got TLSdk=%b expected %b", c, {T, L, S, req_dir, tick}, exp_v);
            end
        end
        phase_start = 1'b0;
        req_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timers();
        test_glitch();
        test_consume();
        test_simultaneous();
        test_restart();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
